// File: rtl/nn_mem_pkg.sv
// Shared constants for the layer weight memories: state encoding, word width, layer depths.
package nn_mem_pkg;

    localparam int DATA_W_DEF = 32;

    localparam int L0_DEPTH = 784;
    localparam int L1_DEPTH = 30;
    localparam int L2_DEPTH = 30;
    localparam int L3_DEPTH = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/weight_mem_writer_if.sv
// Valid/ready weight stream between the host front end and the weight memory writer.
interface weight_mem_writer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/wm_ram.sv
// Single write port, asynchronous read RAM; out-of-range reads return zero.
module wm_ram #(
    parameter int DEPTH  = 784,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [31:0]       raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read with range guard so aliased high addresses read zero.
    always_comb begin
        if (raddr_i < 32'(DEPTH)) begin
            rdata_o = mem_q[raddr_i[ADDR_W-1:0]];
        end else begin
            rdata_o = {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/weight_mem_writer.sv
// Loads one layer of weights from a valid/ready stream into RAM and serves async reads.
// Optional WEIGHT_MEM_WRITER_CHECKSUM_EN adds a running sum and a compare against expected_sum.
module weight_mem_writer
    import nn_mem_pkg::*;
#(
    parameter int NUM_OF_INPUTS = L0_DEPTH,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ADDR_W        = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    weight_mem_writer_if.slave   stream,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W:0]      wr_count,
    input  logic [31:0]          r_add,
    output logic [DATA_W-1:0]    w_out
`ifdef WEIGHT_MEM_WRITER_CHECKSUM_EN
    ,
    input  logic [DATA_W-1:0]    expected_sum,
    output logic [DATA_W-1:0]    checksum,
    output logic                 checksum_ok
`endif
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(NUM_OF_INPUTS);

    logic [1:0]      state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic [ADDR_W:0] cnt_inc_s;
    logic            in_ready_q, busy_q, done_q;
    logic            xfer_s, last_s, load_start_s;

    // in_ready_q is only ever high in LOAD, so it alone qualifies a transfer.
    assign xfer_s       = stream.in_valid && in_ready_q;
    assign cnt_inc_s    = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    assign last_s       = xfer_s && (cnt_inc_s == LAST_CNT);
    assign load_start_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state and word-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = {(ADDR_W+1){1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (xfer_s) begin
                    cnt_d   = cnt_inc_s;
                    state_d = last_s ? ST_DONE : ST_LOAD;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {(ADDR_W+1){1'b0}};
            end
        endcase
    end

    // State, counter and status flags; flags decode the next state so they register with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {(ADDR_W+1){1'b0}};
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= (state_d == ST_LOAD);
            busy_q     <= (state_d == ST_LOAD);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign stream.in_ready = in_ready_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign wr_count        = cnt_q;

    wm_ram #(
        .DEPTH  (NUM_OF_INPUTS),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (xfer_s),
        .waddr_i (cnt_q[ADDR_W-1:0]),
        .wdata_i (stream.in_data),
        .raddr_i (r_add),
        .rdata_o (w_out)
    );

`ifdef WEIGHT_MEM_WRITER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d, sum_next_s;
    logic              ok_q, ok_d;

    assign sum_next_s = sum_q + stream.in_data;

    // Running sum; the verdict is taken from the sum including the final word.
    always_comb begin
        sum_d = sum_q;
        ok_d  = ok_q;
        if (load_start_s) begin
            sum_d = {DATA_W{1'b0}};
            ok_d  = 1'b0;
        end else if (xfer_s) begin
            sum_d = sum_next_s;
            ok_d  = last_s ? (sum_next_s == expected_sum) : ok_q;
        end else begin
            sum_d = sum_q;
            ok_d  = ok_q;
        end
    end

    // Checksum registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= {DATA_W{1'b0}};
            ok_q  <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ok_q  <= ok_d;
        end
    end

    assign checksum    = sum_q;
    assign checksum_ok = ok_q;
`else
    logic unused_start_s;
    assign unused_start_s = load_start_s;
`endif

endmodule
